// File: rtl/fme_pkg.sv
// Shared definitions for the fractional motion estimation controller:
// candidate count, centre index, FSM state encoding and the decode from
// candidate index to a (dx, dy) offset on the 3x3 search grid.
package fme_pkg;

    localparam int         NUM_CAND   = 9;
    localparam logic [3:0] CENTER_IDX = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        HIP,
        HSATD,
        HLATCH,
        QIP,
        QSATD,
        DONE
    } fme_state_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } cand_off_t;

    // Row-major 3x3 grid: dx = (idx mod 3) - 1, dy = (idx div 3) - 1.
    // Anything outside 0..8 decodes to the centre (zero offset).
    function automatic cand_off_t cand_offset(input logic [3:0] idx);
        cand_off_t off;
        off.dx = 2'sb00;
        off.dy = 2'sb00;
        case (idx)
            4'd0: begin off.dx = -2'sd1; off.dy = -2'sd1; end
            4'd1: begin off.dx =  2'sd0; off.dy = -2'sd1; end
            4'd2: begin off.dx =  2'sd1; off.dy = -2'sd1; end
            4'd3: begin off.dx = -2'sd1; off.dy =  2'sd0; end
            4'd4: begin off.dx =  2'sd0; off.dy =  2'sd0; end
            4'd5: begin off.dx =  2'sd1; off.dy =  2'sd0; end
            4'd6: begin off.dx = -2'sd1; off.dy =  2'sd1; end
            4'd7: begin off.dx =  2'sd0; off.dy =  2'sd1; end
            4'd8: begin off.dx =  2'sd1; off.dy =  2'sd1; end
            default: begin off.dx = 2'sd0; off.dy = 2'sd0; end
        endcase
        return off;
    endfunction

endpackage

// File: rtl/fme_ctrl.sv
// Fractional motion estimation sequencer: runs half-pel interpolation and
// SATD over 9 candidates, latches the half-pel winner, repeats at quarter-pel,
// then combines both winners with the integer MV into a quarter-pel MV.
// The refined MV and error flag are presented during the done cycle and then
// held in registers until the next completed block.
module fme_ctrl #(
    parameter int HIP_CYC  = 4,
    parameter int QIP_CYC  = 1,
    parameter int SATD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  int_mv_x,
    input  logic [7:0]  int_mv_y,
    input  logic [3:0]  best,
    output logic        hip_start,
    output logic        satd_rst1,
    output logic        satd_rst2,
    output logic        quat_en,
    output logic [3:0]  cand_idx,
    output logic        busy,
    output logic        done,
    output logic        best_err,
    output logic [10:0] mv_x,
    output logic [10:0] mv_y
);
    import fme_pkg::*;

    localparam int SATD_CYC = NUM_CAND + SATD_LAT;
    localparam int MAX_HQ   = (HIP_CYC > QIP_CYC) ? HIP_CYC : QIP_CYC;
    localparam int MAX_CYC  = (MAX_HQ > SATD_CYC) ? MAX_HQ : SATD_CYC;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HIP_LAST  = CNT_W'(HIP_CYC - 1);
    localparam logic [CNT_W-1:0] QIP_LAST  = CNT_W'(QIP_CYC - 1);
    localparam logic [CNT_W-1:0] SATD_LAST = CNT_W'(SATD_CYC - 1);
    localparam logic [CNT_W-1:0] CAND_END  = CNT_W'(NUM_CAND);
    localparam logic [3:0]       LAST_IDX  = 4'(NUM_CAND - 1);

    fme_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       int_x_q, int_x_d;
    logic [7:0]       int_y_q, int_y_d;
    logic [3:0]       half_best_q, half_best_d;
    logic             half_err_q, half_err_d;
    logic [10:0]      mv_x_q, mv_x_d;
    logic [10:0]      mv_y_q, mv_y_d;
    logic             best_err_q, best_err_d;

    logic [3:0]  best_s;
    logic        best_bad;
    logic [3:0]  sweep_idx;
    cand_off_t   half_off;
    cand_off_t   quat_off;
    logic [10:0] mv_x_new;
    logic [10:0] mv_y_new;

    // Clamp the engine's answer into range and build the refined MV from it.
    always_comb begin
        best_bad  = (best > LAST_IDX);
        best_s    = best_bad ? CENTER_IDX : best;
        sweep_idx = (cnt_q < CAND_END) ? 4'(cnt_q) : LAST_IDX;
        half_off  = cand_offset(half_best_q);
        quat_off  = cand_offset(best_s);
        mv_x_new  = {int_x_q[7], int_x_q, 2'b00}
                  + {{8{half_off.dx[1]}}, half_off.dx, 1'b0}
                  + {{9{quat_off.dx[1]}}, quat_off.dx};
        mv_y_new  = {int_y_q[7], int_y_q, 2'b00}
                  + {{8{half_off.dy[1]}}, half_off.dy, 1'b0}
                  + {{9{quat_off.dy[1]}}, quat_off.dy};
    end

    // Next-state, datapath updates and Moore outputs, with abort and reset overrides last.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_x_d     = int_x_q;
        int_y_d     = int_y_q;
        half_best_d = half_best_q;
        half_err_d  = half_err_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;
        best_err_d  = best_err_q;

        hip_start = 1'b0;
        satd_rst1 = 1'b1;
        satd_rst2 = 1'b1;
        quat_en   = 1'b0;
        cand_idx  = 4'd0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        best_err  = best_err_q;
        mv_x      = mv_x_q;
        mv_y      = mv_y_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HIP;
                    cnt_d      = '0;
                    int_x_d    = int_mv_x;
                    int_y_d    = int_mv_y;
                    best_err_d = 1'b0;
                end
            end
            HIP: begin
                hip_start = (cnt_q == '0);
                if (cnt_q == HIP_LAST) begin
                    state_d = HSATD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HSATD: begin
                satd_rst1 = 1'b0;
                cand_idx  = sweep_idx;
                if (cnt_q == SATD_LAST) begin
                    state_d = HLATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HLATCH: begin
                half_best_d = best_s;
                half_err_d  = best_bad;
                state_d     = QIP;
                cnt_d       = '0;
            end
            QIP: begin
                quat_en = 1'b1;
                if (cnt_q == QIP_LAST) begin
                    state_d = QSATD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            QSATD: begin
                quat_en   = 1'b1;
                satd_rst2 = 1'b0;
                cand_idx  = sweep_idx;
                if (cnt_q == SATD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                done       = 1'b1;
                mv_x_d     = mv_x_new;
                mv_y_d     = mv_y_new;
                best_err_d = half_err_q | best_bad;
                mv_x       = mv_x_new;
                mv_y       = mv_y_new;
                best_err   = half_err_q | best_bad;
                state_d    = IDLE;
                cnt_d      = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            mv_x_d     = mv_x_q;
            mv_y_d     = mv_y_q;
            best_err_d = best_err_q;
            hip_start  = 1'b0;
            satd_rst1  = 1'b1;
            satd_rst2  = 1'b1;
            quat_en    = 1'b0;
            cand_idx   = 4'd0;
            done       = 1'b0;
            best_err   = best_err_q;
            mv_x       = mv_x_q;
            mv_y       = mv_y_q;
        end

        if (rst) begin
            hip_start = 1'b0;
            satd_rst1 = 1'b1;
            satd_rst2 = 1'b1;
            quat_en   = 1'b0;
            cand_idx  = 4'd0;
            busy      = 1'b0;
            done      = 1'b0;
            best_err  = 1'b0;
            mv_x      = 11'd0;
            mv_y      = 11'd0;
        end
    end

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            int_x_q     <= 8'd0;
            int_y_q     <= 8'd0;
            half_best_q <= CENTER_IDX;
            half_err_q  <= 1'b0;
            mv_x_q      <= 11'd0;
            mv_y_q      <= 11'd0;
            best_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_x_q     <= int_x_d;
            int_y_q     <= int_y_d;
            half_best_q <= half_best_d;
            half_err_q  <= half_err_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
            best_err_q  <= best_err_d;
        end
    end

endmodule

// File: doc/fme_ctrl.md
FME_CTRL -- requirements
Module: fme_ctrl

Interface
REQ-001 SHALL have parameters: HIP_CYC, default 4, half-pel interpolation cycles; QIP_CYC, default 1, quarter-pel interpolation cycles; SATD_LAT, default 2, SATD pipeline latency after the last candidate.
REQ-002 SHALL have port clk, in, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, in, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, in, 1, a one-cycle request to refine one block.
REQ-005 SHALL have port abort, in, 1, which cancels the refinement in progress.
REQ-006 SHALL have port int_mv_x, in, 8, signed integer-pel MV x.
REQ-007 SHALL have port int_mv_y, in, 8, signed integer-pel MV y.
REQ-008 SHALL have port best, in, 4, best candidate index from the SATD engine.
REQ-009 SHALL have port hip_start, out, 1, a one-cycle pulse that starts half-pel interpolation.
REQ-010 SHALL have port satd_rst1, out, 1, reset for the half-pel SATD engine, active-high.
REQ-011 SHALL have port satd_rst2, out, 1, reset for the quarter-pel SATD engine, active-high.
REQ-012 SHALL have port quat_en, out, 1, quarter-pel interpolation enable.
REQ-013 SHALL have port cand_idx, out, 4, the candidate currently fed to SATD, range 0..8.
REQ-014 SHALL have ports busy (out, 1), done (out, 1, one-cycle pulse) and best_err (out, 1, valid with done).
REQ-015 SHALL have ports mv_x and mv_y, out, 11 each, signed quarter-pel refined MV.

Function
REQ-016 SHALL implement FSM states IDLE, HIP, HSATD, HLATCH, QIP, QSATD, DONE.
REQ-017 SHALL, when start=1 in IDLE, capture int_mv_x/y and go to HIP; start outside IDLE is ignored.
REQ-018 SHALL hold HIP for HIP_CYC cycles, with hip_start=1 in the first HIP cycle only.
REQ-019 SHALL hold HSATD for 9+SATD_LAT cycles with satd_rst1=0; cand_idx = 0,1,..,8 on the first 9 cycles, then held at 8.
REQ-020 SHALL, in HLATCH (1 cycle), register best as half_best, with satd_rst1=1 again.
REQ-021 SHALL hold QIP for QIP_CYC cycles with quat_en=1; quat_en is also 1 throughout QSATD.
REQ-022 SHALL sequence QSATD the same as HSATD but drive satd_rst2 instead of satd_rst1.
REQ-023 SHALL, in DONE (1 cycle), register best as quat_best, pulse done=1, update mv_x/y, and return to IDLE.
REQ-024 SHALL, with start sampled at cycle 0, assert done at cycle HIP_CYC+QIP_CYC+2*(9+SATD_LAT)+2, which is 29 at defaults.
REQ-025 SHALL map candidate idx to offset dx=(idx mod 3)-1, dy=(idx div 3)-1; idx 4 is the centre.
REQ-026 SHALL compute mv_x = 4*int_mv_x + 2*dx(half_best) + dx(quat_best), sign-extended to 11 bits with no saturation; mv_y is computed likewise with dy.
REQ-027 SHALL treat any captured best greater than 8 as 4 (zero offset) and set best_err=1 for that block; best_err is cleared at the next start.
REQ-028 SHALL keep mv_x/y and best_err stable from done until the next DONE; they are not changed by abort.
REQ-029 SHALL keep busy=1 in every state except IDLE.
REQ-030 SHALL keep cand_idx=0 outside HSATD/QSATD.
REQ-031 SHALL, when abort=1 in a non-IDLE state, go to IDLE next cycle with no done pulse, satd_rst1/2=1 and quat_en=0.
REQ-032 SHALL give abort priority over DONE; abort in IDLE has no effect.
REQ-033 SHALL, when start and abort are both 1 in IDLE, accept start.
REQ-034 SHALL give rst priority over abort and start.

Reset
REQ-035 SHALL, while rst=1, force state IDLE, busy=0, done=0, hip_start=0, quat_en=0, satd_rst1=1, satd_rst2=1, cand_idx=0, mv_x/y=0 and best_err=0.
REQ-036 SHALL, on rst asserted mid-operation, abandon the block at the next edge with no done pulse; the previous mv_x/y are cleared.

Structure
REQ-037 SHALL place NUM_CAND=9, CENTER_IDX=4, the state enum and the idx-to-offset function in shared package fme_pkg.
REQ-038 SHALL be a single module with no sub-modules; the offset decode is the package function.

Verification
REQ-039 SHALL verify nominal defaults: start with int_mv=(3,-2), best=0 at HLATCH, best=8 at DONE -> done at cycle 29, mv_x=11, mv_y=-9.
REQ-040 SHALL verify centre: int_mv=(0,0), best=4 at both captures -> mv=(0,0), best_err=0, and cand_idx sequence 0..8 seen twice.
REQ-041 SHALL verify extremes: int_mv=(-128,127), best=0 then 0 -> mv=(-515,505), no wrap.
REQ-042 SHALL verify abort on cycle 20 -> IDLE at 21, no done, prior mv kept; a start on cycle 22 completes normally.
REQ-043 SHALL verify a start repeated on cycles 1..28 is ignored and exactly one done occurs.
REQ-044 SHALL verify invalid best=12 at HLATCH -> half offset 0 and best_err=1 with done; rst at cycle 10 -> all REQ-035 values by the next cycle.
